// File: rtl/segscan_pkg.sv
// Shared constants for the segscan display controller: register map, CTRL bit
// positions and the all-segments-off pattern.
package segscan_pkg;

  // Register indices on the CPU byte bus
  localparam logic [2:0] REG_DIGIT0 = 3'd0;
  localparam logic [2:0] REG_DIGIT1 = 3'd1;
  localparam logic [2:0] REG_DIGIT2 = 3'd2;
  localparam logic [2:0] REG_DIGIT3 = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_DP     = 3'd5;
  localparam logic [2:0] REG_BRIGHT = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  // CTRL layout: bit0 enable, bits[7:4] raw mode for digits 3..0
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_RAW_LSB = 4;

  // Active-low segments: all ones means every segment (and the DP) is dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Value returned on the data bus when the block is not selected
  localparam logic [7:0] BUS_IDLE = 8'hFF;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to 7-segment pattern, active-high, bit order gfedcba.
module hex7_decode (
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Standard hex glyphs; lower-case b and d keep them distinct from 8 and 0
  always_comb begin
    seg_o = 7'h00;
    unique case (value_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
    endcase
  end

endmodule

// File: rtl/segscan_ctrl.sv
// Memory-mapped 4-digit multiplexed 7-segment controller. A prescaled counter
// walks the digits; the first BLANK cycles of each slot drive nothing to stop
// ghosting. seg/dig are registered and reflect the previous cycle's state.
// Optional feature: define SEGSCAN_BRIGHTNESS_EN for the BRIGHT register, which
// shortens the drive window within each slot.
module segscan_ctrl
  import segscan_pkg::*;
#(
  parameter int unsigned PRESCALE = 520,
  parameter int unsigned BLANK    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [7:0] seg,
  output logic [3:0] dig
);

  localparam int unsigned    CntW     = $clog2(PRESCALE);
  localparam logic [CntW-1:0] CntLast  = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK);

  logic [7:0]      digit_q [4];
  logic            en_q;
  logic [3:0]      raw_q;
  logic [3:0]      dp_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [7:0]      seg_q;
  logic [3:0]      dig_q;
`ifdef SEGSCAN_BRIGHTNESS_EN
  logic [3:0]      bright_q;
`endif

  logic       wr_en;
  logic       blank_phase;
  logic       in_window;
  logic [7:0] cur_digit;
  logic [6:0] hex_seg;
  logic [7:0] seg_pat;

  assign wr_en       = cs & ~read;
  assign blank_phase = en_q & (cnt_q < BlankCnt);
  assign cur_digit   = digit_q[idx_q];

  // Register file: CPU writes land on the edge where cs=1 and read=0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 4; n++) digit_q[n] <= 8'h00;
      en_q  <= 1'b0;
      raw_q <= 4'h0;
      dp_q  <= 4'h0;
`ifdef SEGSCAN_BRIGHTNESS_EN
      bright_q <= 4'hF;
`endif
    end else if (wr_en) begin
      case (address)
        REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3: digit_q[address[1:0]] <= din;
        REG_CTRL: begin
          en_q  <= din[CTRL_EN_BIT];
          raw_q <= din[CTRL_RAW_LSB +: 4];
        end
        REG_DP: dp_q <= din[3:0];
`ifdef SEGSCAN_BRIGHTNESS_EN
        REG_BRIGHT: bright_q <= din[3:0];
`endif
        default: ;
      endcase
    end
  end

  // Scan sequencer: held at digit 0, count 0 while disabled so enabling restarts cleanly
  always_ff @(posedge clk) begin
    if (rst || !en_q) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef SEGSCAN_BRIGHTNESS_EN
  logic [31:0] on_len;
  // Drive only the first on_len cycles after the blank; BRIGHT=15 spans the full window
  always_comb begin
    on_len    = ((PRESCALE - BLANK) * (32'(bright_q) + 32'd1)) >> 4;
    in_window = (32'(cnt_q) >= BLANK) && (32'(cnt_q) < BLANK + on_len);
  end
`else
  // Whole slot after the blank interval drives the digit
  always_comb begin
    in_window = (cnt_q >= BlankCnt);
  end
`endif

  hex7_decode u_hex7_decode (
    .value_i (cur_digit[3:0]),
    .seg_o   (hex_seg)
  );

  // Segment pattern for the digit currently selected, before output gating
  always_comb begin
    seg_pat      = SEG_BLANK;
    seg_pat[6:0] = raw_q[idx_q] ? ~cur_digit[6:0] : ~hex_seg;
    seg_pat[7]   = ~dp_q[idx_q];
  end

  // Registered drive: dark outside the window or when disabled
  always_ff @(posedge clk) begin
    if (rst || !en_q || !in_window) begin
      seg_q <= SEG_BLANK;
      dig_q <= 4'b0000;
    end else begin
      seg_q <= seg_pat;
      dig_q <= onehot4(idx_q);
    end
  end

  assign seg = seg_q;
  assign dig = dig_q;

  // Read mux; unselected bus floats high
  always_comb begin
    dout = BUS_IDLE;
    if (cs) begin
      case (address)
        REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3: dout = digit_q[address[1:0]];
        REG_CTRL:   dout = {raw_q, 3'b000, en_q};
        REG_DP:     dout = {4'h0, dp_q};
`ifdef SEGSCAN_BRIGHTNESS_EN
        REG_BRIGHT: dout = {4'h0, bright_q};
`else
        REG_BRIGHT: dout = 8'h00;
`endif
        REG_STATUS: dout = {5'b00000, blank_phase, idx_q};
        default:    dout = BUS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segscan_ctrl.sv
// Directed bench for segscan_ctrl at PRESCALE=8, BLANK=2. Build with
// SEGSCAN_BRIGHTNESS_EN defined to exercise the BRIGHT register.
module tb_segscan_ctrl;

  localparam int unsigned PRESCALE = 8;
  localparam int unsigned BLANK    = 2;
`ifdef SEGSCAN_BRIGHTNESS_EN
  localparam logic [7:0] BRIGHT_RST = 8'h0F;
  localparam int         DIM_END    = 5;  // BRIGHT=7: on_len=3, drive counts 2..4
`else
  localparam logic [7:0] BRIGHT_RST = 8'h00;
  localparam int         DIM_END    = 8;  // no feature: full window
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       read = 1'b1;
  logic [2:0] address = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] seg;
  logic [3:0] dig;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int on_end = 8;
  logic [7:0] exp_segs [4];

  segscan_ctrl #(
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .read    (read),
    .address (address),
    .din     (din),
    .dout    (dout),
    .seg     (seg),
    .dig     (dig)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; read = 1'b0; address = a; din = d;
    tick();
    cs = 1'b0; read = 1'b1;
  endtask

  task automatic rd_check(input logic [2:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b1; read = 1'b1; address = a;
    #1;
    check8(tag, dout, exp);
    cs = 1'b0;
  endtask

  // k = edges since the enabling CTRL write; outputs show the state at edge k-1
  task automatic check_scan(input int k);
    int c, i, sc;
    logic [7:0] ed, es, st;
    c = (k - 1) % 8;
    i = ((k - 1) / 8) % 4;
    if (c >= 2 && c < on_end) begin
      ed = {4'h0, 4'b0001 << i};
      es = exp_segs[i];
    end else begin
      ed = 8'h00;
      es = 8'hFF;
    end
    check8($sformatf("dig k=%0d", k), {4'h0, dig}, ed);
    check8($sformatf("seg k=%0d", k), seg, es);
    sc = k % 8;
    st = 8'((k / 8) % 4);
    if (sc < 2) st[2] = 1'b1;
    rd_check(3'd7, st, $sformatf("status k=%0d", k));
  endtask

  initial begin
    exp_segs[0] = 8'hF9; exp_segs[1] = 8'hA4; exp_segs[2] = 8'hB0; exp_segs[3] = 8'h99;

    // Reset
    repeat (3) tick();
    check8("reset dig", {4'h0, dig}, 8'h00);
    check8("reset seg", seg, 8'hFF);
    rst = 1'b0;
    for (int a = 0; a < 8; a++) rd_check(3'(a), (a == 6) ? BRIGHT_RST : 8'h00, "reset reg");

    // Hex scan across all four digits including the 3 -> 0 wrap
    wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h03); wr(3'd3, 8'h04);
    wr(3'd4, 8'h01);
    for (int k = 1; k <= 52; k++) begin
      tick();
      check_scan(k);
    end

    // Disable while digit 2 is driving: the write edge still shows it, next edge blanks
    wr(3'd4, 8'h00);
    check8("disable edge dig", {4'h0, dig}, 8'h04);
    check8("disable edge seg", seg, 8'hB0);
    tick();
    check8("disabled dig", {4'h0, dig}, 8'h00);
    check8("disabled seg", seg, 8'hFF);
    rd_check(3'd7, 8'h00, "disabled status");

    // Re-enable restarts at digit 0, count 0
    wr(3'd4, 8'h01);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_scan(k);
    end

    // Raw mode on digit 0 with its decimal point lit
    wr(3'd4, 8'h00);
    wr(3'd0, 8'h49);
    wr(3'd5, 8'h01);
    wr(3'd4, 8'h11);
    exp_segs[0] = 8'h36;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_scan(k);
    end

    // Bus behaviour
    wr(3'd4, 8'h10);
    cs = 1'b0; address = 3'd0;
    #1;
    check8("cs0 dout", dout, 8'hFF);
    wr(3'd7, 8'hFF);
    rd_check(3'd0, 8'h49, "after st wr d0");
    rd_check(3'd1, 8'h02, "after st wr d1");
    rd_check(3'd2, 8'h03, "after st wr d2");
    rd_check(3'd3, 8'h04, "after st wr d3");
    rd_check(3'd4, 8'h10, "after st wr ctrl");
    rd_check(3'd5, 8'h01, "after st wr dp");
    rd_check(3'd6, BRIGHT_RST, "after st wr bright");
    rd_check(3'd7, 8'h00, "after st wr status");
    wr(3'd4, 8'hFE);
    rd_check(3'd4, 8'hF0, "ctrl reserved bits");
    wr(3'd5, 8'hFF);
    rd_check(3'd5, 8'h0F, "dp reserved bits");
`ifndef SEGSCAN_BRIGHTNESS_EN
    wr(3'd6, 8'h07);
    rd_check(3'd6, 8'h00, "bright absent");
`endif

    // Reset mid-scan wins over a simultaneous write
    wr(3'd4, 8'h01);
    repeat (10) tick();
    rst = 1'b1; cs = 1'b1; read = 1'b0; address = 3'd0; din = 8'hAA;
    tick();
    rst = 1'b0; cs = 1'b0; read = 1'b1;
    check8("midrst dig", {4'h0, dig}, 8'h00);
    check8("midrst seg", seg, 8'hFF);
    rd_check(3'd0, 8'h00, "midrst d0");
    rd_check(3'd4, 8'h00, "midrst ctrl");
    rd_check(3'd5, 8'h00, "midrst dp");
    rd_check(3'd7, 8'h00, "midrst status");

    // Brightness window (full window when the feature is absent)
    wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h03); wr(3'd3, 8'h04);
    wr(3'd6, 8'h07);
`ifdef SEGSCAN_BRIGHTNESS_EN
    rd_check(3'd6, 8'h07, "bright rw");
`endif
    exp_segs[0] = 8'hF9;
    on_end = DIM_END;
    wr(3'd4, 8'h01);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_scan(k);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
